// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: run-state encoding,
// default counter width and a parameter range helper.
package tick_sched_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // True when val is representable in an unsigned counter of width w.
  function automatic bit fits(input int unsigned val, input int unsigned w);
    return (w >= 32) || (val < (32'd1 << w));
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler gated by run: one-cycle strobe on the
// terminal count, plus a toggle that flips at the end of every strobe cycle.
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int unsigned DIV   = 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic en,
  output logic tgl
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign en = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tgl <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      tgl <= 1'b0;
    end else if (en) begin
      cnt <= '0;
      tgl <= ~tgl;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Run controller and three-rate enable scheduler: IDLE/RUN/DONE sequencing of
// a fixed-length run, with independent fast/medium/slow prescalers.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned FAST_DIV   = 1,
  parameter int unsigned MED_DIV    = 100,
  parameter int unsigned SLOW_DIV   = 1000,
  parameter int unsigned RUN_CYCLES = 10000,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             fast_en,
  output logic             med_en,
  output logic             slow_en,
  output logic             fast_tgl,
  output logic             med_tgl,
  output logic             slow_tgl,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] elapsed
);

  if (FAST_DIV < 1 || MED_DIV < 1 || SLOW_DIV < 1 || RUN_CYCLES < 1 ||
      !fits(FAST_DIV, CNT_W) || !fits(MED_DIV, CNT_W) ||
      !fits(SLOW_DIV, CNT_W) || !fits(RUN_CYCLES, CNT_W)) begin : g_param_check
    $error("tick_scheduler: divider or run length out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  state_t state, state_nxt;
  logic   clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort outranks both start (in IDLE) and completion (in RUN).
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        state_nxt = RUN;
        clr       = 1'b1;
      end
      RUN: begin
        if (abort)                    state_nxt = IDLE;
        else if (elapsed == RUN_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     elapsed <= '0;
    else if (clr)   elapsed <= '0;
    else if (busy)  elapsed <= elapsed + CNT_W'(1);
  end

  tick_prescaler #(.DIV(FAST_DIV), .CNT_W(CNT_W)) u_fast (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(busy), .en(fast_en), .tgl(fast_tgl)
  );

  tick_prescaler #(.DIV(MED_DIV), .CNT_W(CNT_W)) u_med (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(busy), .en(med_en), .tgl(med_tgl)
  );

  tick_prescaler #(.DIV(SLOW_DIV), .CNT_W(CNT_W)) u_slow (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(busy), .en(slow_en), .tgl(slow_tgl)
  );

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: three configurations checked every
// cycle against a run-index arithmetic model, plus vector table and sequences.
module tb_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic [2:0]  abort = '0;
  logic [2:0]  fen, men, sen, ftg, mtg, stg, busy, done;
  logic [31:0] elapsed [3];
  logic [2:0]  chk = '0;

  int tests = 0;
  int fails = 0;

  // Per-instance configuration: fast, medium, slow dividers and run length.
  int unsigned cf [3] = '{1, 1, 1};
  int unsigned cm [3] = '{100, 3, 1};
  int unsigned cs [3] = '{1000, 6, 1};
  int unsigned cr [3] = '{10000, 12, 1};

  always #5 clk = ~clk;

  tick_scheduler #(.FAST_DIV(1), .MED_DIV(100), .SLOW_DIV(1000), .RUN_CYCLES(10000)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .fast_en(fen[0]), .med_en(men[0]), .slow_en(sen[0]),
    .fast_tgl(ftg[0]), .med_tgl(mtg[0]), .slow_tgl(stg[0]),
    .busy(busy[0]), .done(done[0]), .elapsed(elapsed[0])
  );

  tick_scheduler #(.FAST_DIV(1), .MED_DIV(3), .SLOW_DIV(6), .RUN_CYCLES(12)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .fast_en(fen[1]), .med_en(men[1]), .slow_en(sen[1]),
    .fast_tgl(ftg[1]), .med_tgl(mtg[1]), .slow_tgl(stg[1]),
    .busy(busy[1]), .done(done[1]), .elapsed(elapsed[1])
  );

  tick_scheduler #(.FAST_DIV(1), .MED_DIV(1), .SLOW_DIV(1), .RUN_CYCLES(1)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .fast_en(fen[2]), .med_en(men[2]), .slow_en(sen[2]),
    .fast_tgl(ftg[2]), .med_tgl(mtg[2]), .slow_tgl(stg[2]),
    .busy(busy[2]), .done(done[2]), .elapsed(elapsed[2])
  );

  // Reference model: mode 0 idle, 1 running, 2 done; mk = run cycles completed.
  int unsigned mmode [3] = '{0, 0, 0};
  int unsigned mk    [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mmode[i] <= 0;
        mk[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (mmode[i])
          0: if (start[i] && !abort[i]) begin
            mmode[i] <= 1;
            mk[i]    <= 0;
          end
          1: begin
            mk[i] <= mk[i] + 1;
            if (abort[i])               mmode[i] <= 0;
            else if (mk[i] + 1 == cr[i]) mmode[i] <= 2;
          end
          default: mmode[i] <= 0;
        endcase
      end
    end
  end

  // Outputs packed as {busy, done, fast/med/slow en, fast/med/slow tgl, elapsed}.
  function automatic logic [63:0] expv(input int i);
    logic        run = (mmode[i] == 1);
    int unsigned k   = mk[i];
    return 64'({run, mmode[i] == 2,
                run && ((k + 1) % cf[i] == 0),
                run && ((k + 1) % cm[i] == 0),
                run && ((k + 1) % cs[i] == 0),
                ((k / cf[i]) % 2) == 1,
                ((k / cm[i]) % 2) == 1,
                ((k / cs[i]) % 2) == 1,
                k});
  endfunction

  function automatic logic [63:0] actv(input int i);
    return 64'({busy[i], done[i], fen[i], men[i], sen[i], ftg[i], mtg[i], stg[i], elapsed[i]});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (chk[i]) check($sformatf("model_d%0d", i), actv(i), expv(i));
  end

  typedef struct {
    logic        st;
    logic        ab;
    logic        busy;
    logic        done;
    logic        fen;
    logic        men;
    logic        sen;
    int unsigned el;
  } vec_t;

  vec_t vt [18];

  task automatic full_run(input string tag);
    int nb = 0, nf = 0, nm = 0, ns = 0, nd = 0, nchg = 0, bad = 0;
    int last = -1;
    logic prev;
    logic [31:0] el_done = '0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    prev = mtg[0];
    for (int cyc = 0; cyc < 12000; cyc++) begin
      nb += int'(busy[0]);
      nf += int'(fen[0]);
      nm += int'(men[0]);
      ns += int'(sen[0]);
      if (mtg[0] != prev) begin
        if (last >= 0 && cyc - last != 100) bad++;
        last = cyc;
        nchg++;
        prev = mtg[0];
      end
      if (done[0]) begin
        nd++;
        el_done = elapsed[0];
        break;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(nb), 64'd10000);
    check({tag, "_fast_cnt"}, 64'(nf), 64'd10000);
    check({tag, "_med_cnt"}, 64'(nm), 64'd100);
    check({tag, "_slow_cnt"}, 64'(ns), 64'd10);
    check({tag, "_done_seen"}, 64'(nd), 64'd1);
    check({tag, "_elapsed_done"}, 64'(el_done), 64'd10000);
    check({tag, "_med_tgl_edges"}, 64'(nchg), 64'd100);
    check({tag, "_med_tgl_halfperiod"}, 64'(bad), 64'd0);
    @(negedge clk);
    check({tag, "_after_done"}, 64'({busy[0], done[0], elapsed[0]}), 64'({1'b0, 1'b0, 32'd10000}));
  endtask

  initial begin
    vt = '{
      '{1, 1, 0, 0, 0, 0, 0, 0},
      '{1, 0, 1, 0, 1, 0, 0, 0},
      '{1, 0, 1, 0, 1, 0, 0, 1},
      '{0, 0, 1, 0, 1, 1, 0, 2},
      '{0, 0, 1, 0, 1, 0, 0, 3},
      '{0, 0, 1, 0, 1, 0, 0, 4},
      '{0, 0, 1, 0, 1, 1, 1, 5},
      '{0, 0, 1, 0, 1, 0, 0, 6},
      '{0, 0, 1, 0, 1, 0, 0, 7},
      '{0, 0, 1, 0, 1, 1, 0, 8},
      '{0, 0, 1, 0, 1, 0, 0, 9},
      '{0, 0, 1, 0, 1, 0, 0, 10},
      '{1, 0, 1, 0, 1, 1, 1, 11},
      '{1, 0, 0, 1, 0, 0, 0, 12},
      '{1, 0, 0, 0, 0, 0, 0, 12},
      '{1, 0, 1, 0, 1, 0, 0, 0},
      '{0, 1, 0, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 0, 1}
    };

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("reset_d%0d", i), actv(i), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk = 3'b111;

    // Vector table on the 1:3:6 / 12-cycle instance.
    for (int v = 0; v < 18; v++) begin
      start[1] = vt[v].st;
      abort[1] = vt[v].ab;
      @(negedge clk);
      check($sformatf("vec%0d", v),
            64'({busy[1], done[1], fen[1], men[1], sen[1], elapsed[1]}),
            64'({vt[v].busy, vt[v].done, vt[v].fen, vt[v].men, vt[v].sen, vt[v].el}));
    end
    start[1] = 1'b0;
    abort[1] = 1'b0;

    // Single-cycle run: every strobe once, then done, then idle.
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    check("tiny_run", 64'({busy[2], done[2], fen[2], men[2], sen[2], elapsed[2]}),
          64'({5'b10111, 32'd0}));
    @(negedge clk);
    check("tiny_done", 64'({busy[2], done[2], fen[2], men[2], sen[2], elapsed[2]}),
          64'({5'b01000, 32'd1}));
    @(negedge clk);
    check("tiny_idle", 64'({busy[2], done[2], elapsed[2]}), 64'({2'b00, 32'd1}));

    // Random start/abort traffic on the two short-run instances.
    for (int c = 0; c < 3000; c++) begin
      start[1] = ($urandom_range(0, 3) == 0);
      abort[1] = ($urandom_range(0, 19) == 0);
      start[2] = ($urandom_range(0, 2) == 0);
      abort[2] = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    start[2:1] = '0;
    abort[2:1] = '0;

    full_run("run1");

    // Abort during run cycle 50 of a default run.
    begin
      int nm = 0, nd = 0;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      nm += int'(men[0]);
      repeat (49) begin
        @(negedge clk);
        nm += int'(men[0]);
        nd += int'(done[0]);
      end
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      check("abort_state", 64'({busy[0], done[0], elapsed[0]}), 64'({2'b00, 32'd50}));
      repeat (3) begin
        @(negedge clk);
        nd += int'(done[0]);
      end
      check("abort_no_med", 64'(nm), 64'd0);
      check("abort_no_done", 64'(nd), 64'd0);
      check("abort_hold", 64'(elapsed[0]), 64'd50);
    end

    // Asynchronous reset at run cycle 500, then a complete fresh run.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (499) @(negedge clk);
    check("pre_reset_elapsed", 64'(elapsed[0]), 64'd499);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("async_reset_d%0d", i), actv(i), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_run("run2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Single-clock run controller and rate scheduler for the waveform-sample bench. It replaces three free-running clocks of different rates with one `clk` plus three divided enable strobes (fast/medium/slow, default ratio 1:100:1000). It also sequences a bounded run: start, count a fixed number of cycles, signal done. `sub` instances are clocked by `clk` and qualified by one strobe each.

## Interface
Parameters:
- `FAST_DIV`, 1, fast strobe period in `clk` cycles (≥1)
- `MED_DIV`, 100, medium strobe period in `clk` cycles (≥1)
- `SLOW_DIV`, 1000, slow strobe period in `clk` cycles (≥1)
- `RUN_CYCLES`, 10000, run length in `clk` cycles (≥1)
- `CNT_W`, 32, width of all counters; every DIV and `RUN_CYCLES` must be < 2^CNT_W (elaboration-time check)

Ports:
- `clk`  in  1  single clock; one clock, all state on its rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  level-sampled; begins a run when IDLE
- `abort`  in  1  level-sampled; terminates a run immediately
- `fast_en`, `med_en`, `slow_en`  out  1 each  one-cycle enable strobes
- `fast_tgl`, `med_tgl`, `slow_tgl`  out  1 each  toggle on every corresponding strobe (50%-duty waveform view)
- `busy`  out  1  high exactly while in RUN
- `done`  out  1  one-cycle pulse on normal completion
- `elapsed`  out  CNT_W  RUN cycles completed in current/last run

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN: `start`=1 and `abort`=0. Abort has priority when both are asserted in IDLE (stay IDLE).
- Entering RUN clears the three prescale counters, `elapsed`, and all `*_tgl`.
- RUN: each prescaler counts 0..DIV-1 and wraps. Its strobe is high in the cycle where state==RUN and count==DIV-1. Its toggle flips on the edge that ends that cycle.
- Prescalers are independent, not cascaded. Coincident strobes, e.g. cycle where med and slow align, assert together.
- `elapsed` increments every RUN cycle. When `elapsed`==RUN_CYCLES-1 and no abort: RUN→DONE.
- DONE: `done`=1 for one cycle, then DONE→IDLE unconditionally. `start` in DONE is ignored.
- `abort`=1 in RUN: RUN→IDLE next edge, no `done`, `elapsed` frozen at its value after that cycle's increment. Abort takes priority over completion in the same cycle.
- `start` during RUN ignored; no restart.
- Strobes never assert outside RUN. Toggles and `elapsed` hold their values in IDLE/DONE until the next start.
- Reset mid-run: all state returns to reset values immediately (async); no `done`.

## Timing
- Reset values: state IDLE, all strobes 0, all toggles 0, `busy` 0, `done` 0, `elapsed` 0, counters 0.
- `start` sampled at edge N; `busy`=1 from cycle N+1. First `fast_en` at N+FAST_DIV. First `med_en` at N+MED_DIV. First `slow_en` at N+SLOW_DIV.
- `busy` high for exactly RUN_CYCLES cycles; `done` in the following cycle; IDLE the cycle after.
- During DONE and afterwards, `elapsed` = RUN_CYCLES.
- Strobes per full run: floor(RUN_CYCLES/DIV) each.
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- Package `tick_sched_pkg`: state enum (IDLE/RUN/DONE) and a default `CNT_W` constant.
- Sub-module `tick_prescaler`, instantiated three times. Parameters DIV, CNT_W. Inputs `clk`, `rst_n`, `clr`, `run`. Outputs `en`, `tgl`.
- FSM and `elapsed` counter live in the top of the block.

## Test plan
- Reset then `start` pulse, defaults → `busy` for 10000 cycles. Strobe counts: 10000 fast, 100 med, 10 slow. `done` one cycle, `elapsed`=10000. `med_tgl` period 200 cycles.
- FAST_DIV=1, MED_DIV=3, SLOW_DIV=6, RUN_CYCLES=12 → `med_en` at run cycles 3,6,9,12. `slow_en` at 6,12 coincident with `med_en`. `done` at cycle 13.
- `abort` at run cycle 50 (MED_DIV=100) → IDLE next cycle, no `done`, no `med_en`, `elapsed`=50.
- `start`+`abort` together in IDLE → stays IDLE, `busy` 0. `start` held during RUN and DONE → no restart until IDLE, then new run with `elapsed` cleared.
- `rst_n` low at run cycle 500 asynchronously → all outputs 0 immediately. Restart yields a full 10000-cycle run.
- RUN_CYCLES=1, all DIV=1 → `busy` one cycle, one strobe each, `done` next cycle.
